// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WRAP
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority finder: next enabled channel above the current one, or the lowest
// enabled channel when there is no current channel.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    input  logic              i_cur_vld,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_found
);

    // Walks downward so the lowest qualifying channel is the last one written.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (!i_cur_vld || i > int'(i_cur))) begin
                o_next  = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer for a 4:1 mux: dwells on each enabled channel, captures
// Y per channel and publishes the sample word with a one-cycle strobe per pass.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               Y,
    output logic               S1,
    output logic               S0,
    output logic [NUM_CH-1:0]  sample,
    output logic               sample_valid,
    output logic               busy
);

    scan_state_t        r_state, w_state_next;
    logic [SEL_W-1:0]   r_ch, w_ch_next;
    logic [DWELL_W-1:0] r_cnt, w_cnt_next;
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;
    logic [NUM_CH-1:0]  r_mask, w_mask_next;
    logic [NUM_CH-1:0]  r_shadow, w_shadow_next;
    logic [NUM_CH-1:0]  r_sample, w_sample_next;
    logic               r_cont, w_cont_next;
    logic               r_stop, w_stop_next;

    logic [DWELL_W-1:0] w_dwell_in;
    logic [SEL_W-1:0]   w_first_ch, w_hi_ch, w_sel;
    logic               w_first_found, w_hi_found, w_restart;

    mux_scan_next_ch u_first (
        .i_mask    (chan_mask),
        .i_cur     ('0),
        .i_cur_vld (1'b0),
        .o_next    (w_first_ch),
        .o_found   (w_first_found)
    );

    mux_scan_next_ch u_higher (
        .i_mask    (r_mask),
        .i_cur     (r_ch),
        .i_cur_vld (1'b1),
        .o_next    (w_hi_ch),
        .o_found   (w_hi_found)
    );

    assign w_dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_restart  = r_cont && !(r_stop || stop) && w_first_found;

    // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next  = r_state;
        w_ch_next     = r_ch;
        w_cnt_next    = r_cnt;
        w_dwell_next  = r_dwell;
        w_mask_next   = r_mask;
        w_shadow_next = r_shadow;
        w_sample_next = r_sample;
        w_cont_next   = r_cont;
        w_stop_next   = r_stop;

        if (r_state != IDLE && stop) begin
            w_stop_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (start && w_first_found) begin
                    w_mask_next   = chan_mask;
                    w_dwell_next  = w_dwell_in;
                    w_cont_next   = cont;
                    w_shadow_next = '0;
                    w_ch_next     = w_first_ch;
                    w_cnt_next    = w_dwell_in;
                    w_state_next  = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt <= DWELL_W'(1)) begin
                    w_shadow_next[r_ch] = Y;
                    if (w_hi_found) begin
                        w_ch_next  = w_hi_ch;
                        w_cnt_next = r_dwell;
                    end else begin
                        w_sample_next = w_shadow_next;
                        w_state_next  = WRAP;
                    end
                end else begin
                    w_cnt_next = r_cnt - DWELL_W'(1);
                end
            end
            WRAP: begin
                // A zero mask at restart fails w_restart and lands in IDLE too.
                if (w_restart) begin
                    w_mask_next   = chan_mask;
                    w_dwell_next  = w_dwell_in;
                    w_shadow_next = '0;
                    w_ch_next     = w_first_ch;
                    w_cnt_next    = w_dwell_in;
                    w_state_next  = HOLD;
                end else begin
                    w_ch_next    = '0;
                    w_stop_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_ch_next    = '0;
                w_stop_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_mask   <= '0;
            r_shadow <= '0;
            r_sample <= '0;
            r_cont   <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ch     <= w_ch_next;
            r_cnt    <= w_cnt_next;
            r_dwell  <= w_dwell_next;
            r_mask   <= w_mask_next;
            r_shadow <= w_shadow_next;
            r_sample <= w_sample_next;
            r_cont   <= w_cont_next;
            r_stop   <= w_stop_next;
        end
    end

    // During a restarting WRAP the select already shows the next pass's first channel.
    assign w_sel        = (r_state == WRAP && w_restart) ? w_first_ch : r_ch;
    assign S1           = w_sel[1];
    assign S0           = w_sel[0];
    assign sample       = r_sample;
    assign sample_valid = (r_state == WRAP);
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: behavioural 4:1 mux feeds Y back, a
// scoreboard queue holds expected sample words checked on each sample_valid.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       stop;
    logic [3:0] chan_mask;
    logic [7:0] dwell;
    logic       Y;
    logic       S1;
    logic       S0;
    logic [3:0] sample;
    logic       sample_valid;
    logic       busy;
    logic [3:0] I;

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    mux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont         (cont),
        .stop         (stop),
        .chan_mask    (chan_mask),
        .dwell        (dwell),
        .Y            (Y),
        .S1           (S1),
        .S0           (S0),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // Stand-in for the gate-level mux4x1.
    assign Y = I[{S1, S0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (m[c]) lowest = 2'(c);
        end
    endfunction

    // Scoreboard consumer: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("sample", {28'd0, sample}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sel"}, {30'd0, S1, S0}, 32'd0);
        check({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
    endtask

    // One single-mode pass; with hold=1 start stays high and mask/dwell are
    // scrambled mid-pass, which must not disturb the pass in flight.
    task automatic single_pass(input logic [3:0] m, input logic [7:0] d,
                               input logic [3:0] iv, input bit hold, input string tag);
        int         dd;
        logic [1:0] chs[$];
        dd = (d == 8'd0) ? 1 : int'(d);
        for (int c = 0; c < 4; c++) begin
            if (m[c]) chs.push_back(2'(c));
        end
        I         = iv;
        chan_mask = m;
        dwell     = d;
        cont      = 1'b0;
        start     = 1'b1;
        exp_q.push_back(iv & m);
        for (int t = 0; t < chs.size() * dd; t++) begin
            @(negedge clk);
            if (t == 0) begin
                if (hold) begin
                    chan_mask = 4'b0001;
                    dwell     = 8'd7;
                end else begin
                    start = 1'b0;
                end
            end
            check({tag, "_sel"}, {30'd0, S1, S0}, {30'd0, chs[t / dd]});
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_novalid"}, {31'd0, sample_valid}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
        check({tag, "_wrap_busy"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check_idle({tag, "_after"});
        check({tag, "_hold_sample"}, {28'd0, sample}, {28'd0, iv & m});
    endtask

    task automatic cont_run();
        logic [3:0] pm[4];
        logic [3:0] pi[4];
        logic [1:0] chs[$];
        pm = '{4'b0101, 4'b0101, 4'b0101, 4'b0010};
        pi = '{4'b0001, 4'b0000, 4'b0001, 4'b0010};
        chan_mask = pm[0];
        dwell     = 8'd1;
        cont      = 1'b1;
        start     = 1'b1;
        I         = pi[0];
        exp_q.push_back(pi[0] & pm[0]);
        for (int p = 0; p < 4; p++) begin
            chs.delete();
            for (int c = 0; c < 4; c++) begin
                if (pm[p][c]) chs.push_back(2'(c));
            end
            for (int k = 0; k < chs.size(); k++) begin
                @(negedge clk);
                if (k == 0) begin
                    start = 1'b0;
                    if (p < 3) chan_mask = pm[p + 1];
                    else       stop = 1'b1;
                end
                check("cont_sel", {30'd0, S1, S0}, {30'd0, chs[k]});
                check("cont_busy", {31'd0, busy}, 32'd1);
                check("cont_novalid", {31'd0, sample_valid}, 32'd0);
            end
            @(negedge clk);
            check("cont_valid", {31'd0, sample_valid}, 32'd1);
            if (p < 3) begin
                check("cont_wrap_sel", {30'd0, S1, S0}, {30'd0, lowest(pm[p + 1])});
                I = pi[p + 1];
                exp_q.push_back(pi[p + 1] & pm[p + 1]);
            end else begin
                stop = 1'b0;
                cont = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("cont_stopped");
        repeat (3) begin
            @(negedge clk);
            check("cont_stay_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        stop      = 1'b0;
        chan_mask = 4'b0000;
        dwell     = 8'd0;
        I         = 4'b0000;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_sample", {28'd0, sample}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        single_pass(4'b1111, 8'd2, 4'b1101, 1'b0, "full");

        // Abort a pass with reset: nothing is pushed, so any strobe is flagged.
        I         = 4'b1111;
        chan_mask = 4'b1111;
        dwell     = 8'd3;
        start     = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("midpass_busy", {31'd0, busy}, 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        check("midreset_sample", {28'd0, sample}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_stay", {31'd0, busy}, 32'd0);

        single_pass(4'b1111, 8'd3, 4'b0110, 1'b0, "clean");
        single_pass(4'b1010, 8'd0, 4'b1111, 1'b0, "sparse");

        chan_mask = 4'b0000;
        start     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("mask0");
        end
        start = 1'b0;

        single_pass(4'b0110, 8'd2, 4'b0100, 1'b1, "busy_start");

        cont_run();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
